param_data_memory: RTL and testbench
====================================

# param_data_memory

Parametrised single-port synchronous data memory: next generation of the accumulator-datapath scratch RAM, generalised in word width and depth. Stores ACC results and returns operands to the ALU with one-cycle registered reads. Adds a hardware clear sweep after reset, a read-valid strobe, write-first collision behaviour and a sticky access-error flag. Sits between the control unit (addr/enables), the ACC (write data) and the ALU operand mux (read data).

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 5: address width; depth DEPTH = 2**ADDR_WIDTH words.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting accesses; 0 = skip the sweep, contents undefined after power-up.

- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_WIDTH  word address for read and write.
- write_enable  input  1  write write_data to mem[addr] this edge.
- read_enable  input  1  read mem[addr] this edge.
- write_data  input  DATA_WIDTH  data from ACC.
- read_data  output  DATA_WIDTH  registered read data to ALU.
- read_valid  output  1  read_data holds an accepted read.
- busy  output  1  clear sweep in progress; accesses rejected.
- access_err  output  1  sticky: an access was attempted while busy.

## Operation
- FSM states: CLEAR, READY.
- rst sampled high: state <= CLEAR if CLEAR_ON_RESET else READY; clear counter <= 0; read_data <= 0; read_valid <= 0; access_err <= 0; busy <= CLEAR_ON_RESET. Memory array is not reset by rst itself.
- CLEAR: each edge writes 0 to mem[counter] and increments counter. On the edge that writes DEPTH-1: state <= READY, busy <= 0. Counter is ADDR_WIDTH+1 bits wide or compared before increment; no wrap to 0 re-entering the sweep.
- READY, write_enable=1: mem[addr] <= write_data.
- READY, read_enable=1: read_data <= mem[addr], read_valid <= 1. If write_enable=1 in the same cycle (necessarily the same addr), read_data <= write_data (write-first).
- READY, read_enable=0: read_data <= 0, read_valid <= 0.
- CLEAR with write_enable or read_enable high: access dropped (no array write, no read), read_data <= 0, read_valid <= 0, access_err <= 1.
- access_err clears only on rst.
- rst mid-sweep or mid-access: restarts the sweep at address 0; in-flight read is discarded (read_data forced 0).
- CLEAR_ON_RESET=0: never enters CLEAR; busy constant 0 after reset; access_err can never set.

## Timing
- busy is a registered output and is valid during the same cycle the control unit drives its request; the request is accepted on an edge where busy is 0.
- Sweep length: exactly DEPTH edges with rst low; busy is 1 after the reset edge and falls after the DEPTH-th non-reset edge (32 cycles at default).
- Read latency: 1 cycle. Request at edge N -> read_data and read_valid valid after edge N, held until edge N+1.
- Write latency: 1 cycle. Write at edge N is visible to a read issued at edge N+1, and to a read issued at edge N through the bypass.
- Back-to-back reads to different addresses: one result per cycle, no bubbles.
- Reset values: read_data 0, read_valid 0, access_err 0, busy = CLEAR_ON_RESET.

## Test plan
- Reset with defaults, hold rst 2 cycles, release -> busy=1 for exactly 32 cycles, then 0; subsequent reads of addr 0, 17 and 31 return 8'h00 with read_valid=1.
- Write 8'hA5 to addr 3, then read addr 3 in the next cycle -> read_data=8'hA5 one cycle after the read request, read_valid=1; following idle cycle -> read_data=0, read_valid=0.
- Same-cycle write 8'h3C and read at addr 9 -> read_data=8'h3C next cycle; a later read of addr 9 also returns 8'h3C.
- Write 8'hFF to addr 5 during the sweep (cycle 2 after reset) -> access_err=1 and stays 1; after busy falls, read addr 5 -> 8'h00.
- Assert rst at sweep cycle 10, release -> busy remains 1 for a full 32 cycles from release, and access_err=0.
- DATA_WIDTH=16, ADDR_WIDTH=6, CLEAR_ON_RESET=0 -> busy=0 immediately after reset; write 16'hBEEF to addr 63, read back 16'hBEEF; write 16'h1234 to addr 0 and confirm addr 63 is unchanged.

Source files
------------

// File: rtl/param_data_memory.sv
// -----------------------------------------------------------------------------
// param_data_memory
//   Parametrised single-port synchronous scratch RAM for the accumulator
//   datapath. Stores ACC results and returns ALU operands through a one-cycle
//   registered read. After reset an optional hardware sweep zeroes every word;
//   accesses attempted during the sweep are dropped and latch a sticky error.
//   A read and write to the same address in one cycle returns the new data.
//
// Parameters
//   DATA_WIDTH      word width in bits
//   ADDR_WIDTH      address width, depth = 2**ADDR_WIDTH words
//   CLEAR_ON_RESET  1 = zero all words after reset, 0 = skip the sweep
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   addr          word address shared by read and write
//   write_enable  write write_data to mem[addr]
//   read_enable   read mem[addr]
//   write_data    data from the ACC
//   read_data     registered read data to the ALU (0 when no read accepted)
//   read_valid    read_data holds an accepted read
//   busy          clear sweep in progress, accesses rejected
//   access_err    sticky flag: access attempted while busy (cleared by rst)
// -----------------------------------------------------------------------------
module param_data_memory #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  access_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic                  CLR_EN   = (CLEAR_ON_RESET != 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = '1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;
  logic                  r_busy;
  logic                  r_access_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_in_clear;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // The array port is shared between the sweep and normal writes. Nothing
  // is written while rst is high so a reset never corrupts stored contents.
  assign w_in_clear  = (r_state == S_CLEAR);
  assign w_mem_we    = !rst && (w_in_clear || write_enable);
  assign w_mem_addr  = w_in_clear ? r_clr_cnt : addr;
  assign w_mem_wdata = w_in_clear ? '0 : write_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= CLR_EN ? S_CLEAR : S_READY;
      r_clr_cnt    <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_busy       <= CLR_EN;
      r_access_err <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_read_data  <= '0;
          r_read_valid <= 1'b0;
          if (write_enable || read_enable) begin
            r_access_err <= 1'b1;
          end
          // Compare before incrementing: the wrap back to 0 happens only
          // after the state has already left CLEAR.
          if (r_clr_cnt == LAST_ADR) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end
          r_clr_cnt <= r_clr_cnt + 1'b1;
        end
        default: begin
          if (read_enable) begin
            r_read_valid <= 1'b1;
            // Write-first: a same-cycle write forwards its data.
            r_read_data  <= write_enable ? write_data : r_mem[addr];
          end else begin
            r_read_valid <= 1'b0;
            r_read_data  <= '0;
          end
        end
      endcase
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign busy       = r_busy;
  assign access_err = r_access_err;

endmodule

// File: tb/tb_param_data_memory.sv
module tb_param_data_memory;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 8 x 32, clear sweep enabled
  logic        rst;
  logic [4:0]  addr;
  logic        we, re;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rvalid, busy, aerr;

  // Second instance: 16 x 64, no sweep
  logic        rst2;
  logic [5:0]  addr2;
  logic        we2, re2;
  logic [15:0] wdata2;
  logic [15:0] rdata2;
  logic        rvalid2, busy2, aerr2;

  int n_cmp  = 0;
  int n_fail = 0;

  param_data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_enable(we), .read_enable(re),
    .write_data(wdata), .read_data(rdata), .read_valid(rvalid),
    .busy(busy), .access_err(aerr)
  );

  param_data_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .rst(rst2), .addr(addr2), .write_enable(we2), .read_enable(re2),
    .write_data(wdata2), .read_data(rdata2), .read_valid(rvalid2),
    .busy(busy2), .access_err(aerr2)
  );

  // Advance one rising edge and settle; inputs are changed and outputs
  // sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    cyc(); cyc();
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", rdata); end
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    n_cmp++; if (aerr !== 1'b0) begin n_fail++; $display("FAIL reset_aerr got %b want 0", aerr); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin cyc(); n++; end
    n_cmp++; if (n !== 32) begin n_fail++; $display("FAIL sweep_len got %0d want 32", n); end
    // Back-to-back reads of cleared words, one result per cycle
    re = 1'b1; addr = 5'd0;  cyc();
    n_cmp++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin n_fail++; $display("FAIL clr_rd0 got %h/%b want 00/1", rdata, rvalid); end
    addr = 5'd17; cyc();
    n_cmp++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin n_fail++; $display("FAIL clr_rd17 got %h/%b want 00/1", rdata, rvalid); end
    addr = 5'd31; cyc();
    n_cmp++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin n_fail++; $display("FAIL clr_rd31 got %h/%b want 00/1", rdata, rvalid); end
    re = 1'b0; cyc();
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid got %b want 0", rvalid); end
  endtask

  task automatic test_write_read();
    we = 1'b1; addr = 5'd3; wdata = 8'hA5; cyc();
    n_cmp++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin n_fail++; $display("FAIL wr_only got %h/%b want 00/0", rdata, rvalid); end
    we = 1'b0; re = 1'b1; wdata = 8'h00; cyc();
    n_cmp++; if (rdata !== 8'hA5 || rvalid !== 1'b1) begin n_fail++; $display("FAIL rd3 got %h/%b want a5/1", rdata, rvalid); end
    re = 1'b0; cyc();
    n_cmp++; if (rdata !== 8'h00 || rvalid !== 1'b0) begin n_fail++; $display("FAIL rd3_idle got %h/%b want 00/0", rdata, rvalid); end
  endtask

  task automatic test_bypass();
    we = 1'b1; re = 1'b1; addr = 5'd9; wdata = 8'h3C; cyc();
    n_cmp++; if (rdata !== 8'h3C || rvalid !== 1'b1) begin n_fail++; $display("FAIL bypass9 got %h/%b want 3c/1", rdata, rvalid); end
    we = 1'b0; wdata = 8'h00; cyc();
    n_cmp++; if (rdata !== 8'h3C) begin n_fail++; $display("FAIL reread9 got %h want 3c", rdata); end
    re = 1'b0; cyc();
  endtask

  task automatic test_back_to_back();
    re = 1'b1; addr = 5'd3; cyc();
    n_cmp++; if (rdata !== 8'hA5 || rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_3 got %h/%b want a5/1", rdata, rvalid); end
    addr = 5'd9; cyc();
    n_cmp++; if (rdata !== 8'h3C || rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_9 got %h/%b want 3c/1", rdata, rvalid); end
    addr = 5'd4; cyc();
    n_cmp++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_4 got %h/%b want 00/1", rdata, rvalid); end
    re = 1'b0; cyc();
  endtask

  task automatic test_sweep_error();
    int k;
    rst = 1'b1; cyc(); rst = 1'b0;
    cyc();                                   // non-reset edge 1
    we = 1'b1; addr = 5'd5; wdata = 8'hFF; cyc();   // edge 2, rejected
    n_cmp++; if (aerr !== 1'b1) begin n_fail++; $display("FAIL sweep_aerr got %b want 1", aerr); end
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL sweep_rvalid got %b want 0", rvalid); end
    we = 1'b0;
    k = 3;
    while (busy === 1'b1 && k <= 60) begin
      // Edge 31 sweeps word 30; address 2 was already cleared, so a write
      // that slips through would remain visible.
      if (k == 31) begin we = 1'b1; addr = 5'd2; wdata = 8'hFF; end
      else we = 1'b0;
      cyc(); k++;
    end
    we = 1'b0;
    n_cmp++; if (k !== 33) begin n_fail++; $display("FAIL sweep2_len got %0d want 33", k); end
    n_cmp++; if (aerr !== 1'b1) begin n_fail++; $display("FAIL aerr_sticky got %b want 1", aerr); end
    re = 1'b1; addr = 5'd5; cyc();
    n_cmp++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin n_fail++; $display("FAIL rd5 got %h/%b want 00/1", rdata, rvalid); end
    addr = 5'd2; cyc();
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rd2_dropped got %h want 00", rdata); end
    re = 1'b0; cyc();
    n_cmp++; if (aerr !== 1'b1) begin n_fail++; $display("FAIL aerr_hold got %b want 1", aerr); end
  endtask

  task automatic test_mid_sweep_reset();
    int n;
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    re = 1'b1; addr = 5'd1; cyc();           // sets access_err
    re = 1'b0;
    for (int i = 0; i < 4; i++) cyc();       // sweep cycle 10
    n_cmp++; if (aerr !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_rst got aerr=%b busy=%b want 1/1", aerr, busy); end
    rst = 1'b1; cyc(); rst = 1'b0;
    n_cmp++; if (aerr !== 1'b0) begin n_fail++; $display("FAIL midrst_aerr got %b want 0", aerr); end
    n = 0;
    while (busy === 1'b1 && n < 100) begin cyc(); n++; end
    n_cmp++; if (n !== 32) begin n_fail++; $display("FAIL midrst_len got %0d want 32", n); end
    n_cmp++; if (aerr !== 1'b0) begin n_fail++; $display("FAIL midrst_aerr_end got %b want 0", aerr); end
  endtask

  task automatic test_no_clear();
    rst2 = 1'b1; we2 = 1'b0; re2 = 1'b0; addr2 = '0; wdata2 = '0;
    cyc(); rst2 = 1'b0;
    n_cmp++; if (busy2 !== 1'b0 || rdata2 !== 16'h0000 || rvalid2 !== 1'b0) begin n_fail++; $display("FAIL nc_reset got busy=%b rd=%h v=%b want 0/0000/0", busy2, rdata2, rvalid2); end
    we2 = 1'b1; addr2 = 6'd63; wdata2 = 16'hBEEF; cyc();
    n_cmp++; if (aerr2 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL nc_flags got aerr=%b busy=%b want 0/0", aerr2, busy2); end
    we2 = 1'b0; re2 = 1'b1; cyc();
    n_cmp++; if (rdata2 !== 16'hBEEF || rvalid2 !== 1'b1) begin n_fail++; $display("FAIL nc_rd63 got %h/%b want beef/1", rdata2, rvalid2); end
    re2 = 1'b0; we2 = 1'b1; addr2 = 6'd0; wdata2 = 16'h1234; cyc();
    we2 = 1'b0; re2 = 1'b1; addr2 = 6'd63; cyc();
    n_cmp++; if (rdata2 !== 16'hBEEF) begin n_fail++; $display("FAIL nc_rd63_again got %h want beef", rdata2); end
    addr2 = 6'd0; cyc();
    n_cmp++; if (rdata2 !== 16'h1234) begin n_fail++; $display("FAIL nc_rd0 got %h want 1234", rdata2); end
    re2 = 1'b0; cyc();
    n_cmp++; if (rvalid2 !== 1'b0 || rdata2 !== 16'h0000) begin n_fail++; $display("FAIL nc_idle got %h/%b want 0000/0", rdata2, rvalid2); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    rst2 = 1'b1; we2 = 1'b0; re2 = 1'b0; addr2 = '0; wdata2 = '0;
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_sweep_error();
    test_mid_sweep_reset();
    test_no_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
